// File: rtl/nl_adc_phase_decoder.sv
// nl_adc_phase_decoder
// Recovers the 6-bit phase {quadrant, fine} from a sign-magnitude cosine/sine
// sample pair produced by the PE non-linear DAC. Two binary-search engines
// (cos and sin) walk the 16-entry magnitude table one bit per cycle. A single
// rounding cycle then picks the nearest entry, maps the quadrant and selects
// the better-resolved source.
//
// Timing, counted in ena-high cycles:
//   - The accept edge moves the FSM from IDLE to SEARCH.
//   - SEARCH lasts 4 cycles and ROUND lasts 1 cycle.
//   - out_valid is therefore observed high in the 6th cycle after the
//     handshake cycle.
//   - The HOLD->IDLE handshake plus one IDLE cycle gives an initiation
//     interval of 7 cycles.
module nl_adc_phase_decoder #(
  parameter int PHASE_BITWIDTH = 6,
  parameter int MAG_BITWIDTH   = 7,
  parameter int MATCH_TOL      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MAG_BITWIDTH:0]     cos_in,
  input  logic [MAG_BITWIDTH:0]     sin_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PHASE_BITWIDTH-1:0] phase_out,
  output logic                      mismatch
);

  // Fine index width is fixed by the 16-entry table.
  localparam int FINE_BITS = 4;
  // Engine 0 resolves the cosine magnitude; engine 1 resolves the sine.
  localparam int NUM_ENG   = 2;

  // Same magnitude table the DAC uses; strictly increasing, T[0] = 0.
  localparam logic [6:0] MAG_TBL [16] = '{
    7'd0,   7'd15,  7'd29,  7'd42,  7'd54,  7'd65,  7'd75,  7'd84,
    7'd93,  7'd100, 7'd107, 7'd112, 7'd117, 7'd120, 7'd123, 7'd124
  };

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_ROUND  = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  // Table lookup, widened to the sample magnitude width.
  function automatic logic [MAG_BITWIDTH-1:0] tbl(input logic [FINE_BITS-1:0] k);
    return MAG_BITWIDTH'(MAG_TBL[k]);
  endfunction

  // Nearest-neighbour rounding.
  //   - i is the largest index with T[i] <= m.
  //   - Move up only when the upper entry is strictly closer, so a tie
  //     resolves to the lower index.
  //   - i = 15 (m >= 124) saturates at 15.
  function automatic logic [FINE_BITS-1:0] round_idx(
    input logic [MAG_BITWIDTH-1:0] m,
    input logic [FINE_BITS-1:0]    i
  );
    logic [MAG_BITWIDTH-1:0] lo_gap;
    logic [MAG_BITWIDTH-1:0] hi_gap;
    logic [FINE_BITS-1:0]    res;
    lo_gap = '0;
    hi_gap = '0;
    res    = i;
    if (i != 4'd15) begin
      lo_gap = m - tbl(i);
      hi_gap = tbl(i + 4'd1) - m;
      if (hi_gap < lo_gap) res = i + 4'd1;
    end
    return res;
  endfunction

  state_t                                state_q, state_d;
  logic [1:0]                            step_q, step_d;
  logic                                  load_pair;
  logic                                  capture_res;
  logic [NUM_ENG-1:0][MAG_BITWIDTH:0]    samp_q;
  logic [NUM_ENG-1:0][MAG_BITWIDTH-1:0]  mag_w;
  logic [NUM_ENG-1:0][FINE_BITS-1:0]     idx_w;
  logic [PHASE_BITWIDTH-1:0]             phase_q, phase_d;
  logic                                  mismatch_q, mismatch_d;

  // Rounding-stage intermediates.
  logic [1:0]           quad;
  logic [FINE_BITS-1:0] l_cos;
  logic [FINE_BITS-1:0] l_sin;
  logic [FINE_BITS-1:0] l_sel;
  logic [FINE_BITS-1:0] l_diff;

  // FSM next-state and control strobes; ena gating is applied at the registers.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    load_pair   = 1'b0;
    capture_res = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        step_d = 2'd0;
        if (in_valid) begin
          load_pair = 1'b1;
          state_d   = S_SEARCH;
        end
      end
      S_SEARCH: begin
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = S_ROUND;
      end
      S_ROUND: begin
        capture_res = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and step counter; reset wins over everything, ena freezes both.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
    end else if (ena) begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Capture the sample pair at acceptance so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= '0;
    end else if (ena && load_pair) begin
      samp_q <= {sin_in, cos_in};
    end
  end

  // One binary-search engine per magnitude.
  //   - Each SEARCH cycle tries setting the next bit, MSB first.
  //   - The bit is kept when the probed table entry does not exceed the
  //     magnitude.
  //   - After 4 steps srch_q holds the largest i with T[i] <= m.
  for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_eng
    logic [FINE_BITS-1:0] srch_q, srch_d, probe;

    assign mag_w[gi] = samp_q[gi][MAG_BITWIDTH-1:0];
    assign probe     = srch_q | (4'b1000 >> step_q);

    // Search step: clear while idle, otherwise keep the probe bit if it fits.
    always_comb begin
      srch_d = srch_q;
      if (state_q == S_IDLE) begin
        srch_d = '0;
      end else if (state_q == S_SEARCH) begin
        if (tbl(probe) <= mag_w[gi]) srch_d = probe;
      end
    end

    // Search register, held while ena is low.
    always_ff @(posedge clk) begin
      if (rst) begin
        srch_q <= '0;
      end else if (ena) begin
        srch_q <= srch_d;
      end
    end

    assign idx_w[gi] = round_idx(mag_w[gi], srch_q);
  end

  // Rounding stage.
  //   - Quadrant comes from the two sign bits.
  //   - Each source is folded into a fine index.
  //   - The smaller magnitude is picked: that is where the table is steepest.
  //   - Mismatch flags disagreement between the two fine indices.
  always_comb begin
    quad   = {samp_q[0][MAG_BITWIDTH],
              samp_q[0][MAG_BITWIDTH] ^ samp_q[1][MAG_BITWIDTH]};
    // 15 - x on 4 bits is ~x: cos descends in odd quadrants, sin in even ones.
    l_cos  = idx_w[0] ^ {FINE_BITS{quad[0]}};
    l_sin  = idx_w[1] ^ {FINE_BITS{~quad[0]}};
    l_sel  = (mag_w[0] <= mag_w[1]) ? l_cos : l_sin;
    l_diff = (l_cos >= l_sin) ? (l_cos - l_sin) : (l_sin - l_cos);
    phase_d    = PHASE_BITWIDTH'({quad, l_sel});
    mismatch_d = (int'(l_diff) > MATCH_TOL);
  end

  // Result registers, loaded in ROUND and stable through HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      mismatch_q <= 1'b0;
    end else if (ena && capture_res) begin
      phase_q    <= phase_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign phase_out = phase_q;
  assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_nl_adc_phase_decoder.sv
// Testbench for nl_adc_phase_decoder.
//   - The stimulus tasks push the expected result into a scoreboard queue
//     when the pair is accepted.
//   - An independent monitor pops and compares on every output transfer.
//   - Expectations come from a nearest-entry reference decoder and from a
//     DAC model for the sweep.
module tb_nl_adc_phase_decoder;

  localparam int TOL = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] cos_in;
  logic [7:0] sin_in;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] phase_out;
  logic       mismatch;

  always #5 clk = ~clk;

  nl_adc_phase_decoder #(
    .PHASE_BITWIDTH(6),
    .MAG_BITWIDTH  (7),
    .MATCH_TOL     (TOL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cos_in   (cos_in),
    .sin_in   (sin_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .phase_out(phase_out),
    .mismatch (mismatch)
  );

  typedef struct {
    logic [5:0] ph;
    logic       mm;
    int         acc_ena;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  int   ena_cnt = 0;
  bit   prev_ov = 1'b0;
  int   tbl_m [16] = '{0, 15, 29, 42, 54, 65, 75, 84, 93, 100, 107, 112, 117, 120, 123, 124};

  // Wall-clock cycles and effective (ena-high) edges.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ena) ena_cnt <= ena_cnt + 1;
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Index of the table entry closest to m; the first (lower) index wins a tie.
  function automatic int nearest(input int m);
    int best = 0;
    for (int i = 1; i < 16; i++)
      if (absd(tbl_m[i], m) < absd(tbl_m[best], m)) best = i;
    return best;
  endfunction

  // Reference decoder: returns {mismatch, phase}.
  function automatic logic [6:0] ref_decode(input logic [7:0] c, input logic [7:0] s);
    int   mc, ms, q, lc, ls, l;
    logic mm;
    mc = int'(c[6:0]);
    ms = int'(s[6:0]);
    case ({c[7], s[7]})
      2'b00:   q = 0;
      2'b01:   q = 1;
      2'b11:   q = 2;
      default: q = 3;
    endcase
    if (q % 2 == 1) begin
      lc = 15 - nearest(mc);
      ls = nearest(ms);
    end else begin
      lc = nearest(mc);
      ls = 15 - nearest(ms);
    end
    l  = (mc <= ms) ? lc : ls;
    mm = (absd(lc, ls) > TOL);
    return {mm, 6'(q * 16 + l)};
  endfunction

  // DAC model: phase -> {cos, sin}. Descending fine 15 aliases fine 14 (T[1]).
  function automatic logic [15:0] dac(input int p);
    int   q, f, cm, sm;
    logic cs, ss;
    q = p / 16;
    f = p % 16;
    if (q % 2 == 1) begin
      cm = (f == 15) ? tbl_m[1] : tbl_m[15 - f];
      sm = tbl_m[f];
    end else begin
      cm = tbl_m[f];
      sm = tbl_m[15 - f];
    end
    case (q)
      0:       {cs, ss} = 2'b00;
      1:       {cs, ss} = 2'b01;
      2:       {cs, ss} = 2'b11;
      default: {cs, ss} = 2'b10;
    endcase
    return {cs, 7'(cm), ss, 7'(sm)};
  endfunction

  // Offer a pair until accepted; push the expectation at acceptance.
  task automatic send(input logic [7:0] c, input logic [7:0] s,
                      input logic [5:0] ep, input logic em, output int acc);
    int waited = 0;
    bit done   = 1'b0;
    acc = -1;
    @(posedge clk);
    #1;
    cos_in   = c;
    sin_in   = s;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready && ena && !rst) begin
        sb.push_back('{ep, em, ena_cnt});
        acc  = cyc;
        done = 1'b1;
      end else if (++waited > 60) begin
        chk("accept_timeout", int'(in_ready), 1);
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble the inputs; the registered pair must be unaffected.
    cos_in   = 8'($urandom);
    sin_in   = 8'($urandom);
  endtask

  // Wait (bounded) for out_valid; check the wall-clock latency from acceptance.
  task automatic wait_out(input int acc, input int lat, input string nm);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(nm, cyc - acc, lat);
  endtask

  // Monitor: ena-cycle latency on each rising out_valid; compare on each transfer.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) chk("unexpected_out", int'(out_valid), 0);
        else chk("latency_ena", ena_cnt - sb[0].acc_ena, 6);
      end
      if (out_valid && out_ready && ena && sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("phase", int'(phase_out), int'(mon_e.ph));
        chk("mismatch", int'(mismatch), int'(mon_e.mm));
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int          acc;
    int          bad;
    logic [5:0]  held;
    logic [15:0] d;
    logic [6:0]  r;
    logic [7:0]  rc, rs;

    rst       = 1'b1;
    ena       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cos_in    = 8'h00;
    sin_in    = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_phase",     int'(phase_out), 0);
    chk("rst_mismatch",  int'(mismatch),  0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors: round trips, rounding, clamping, mismatch.
    send(8'h41, 8'h6B, 6'h05, 1'b0, acc);
    wait_out(acc, 6, "latency_wall");
    send(8'hAA, 8'hF5, 6'h23, 1'b0, acc);
    send(8'h78, 8'h9D, 6'h12, 1'b0, acc);
    send(8'h46, 8'h6B, 6'h05, 1'b0, acc);
    send(8'h47, 8'h6B, 6'h06, 1'b0, acc);
    send(8'h7F, 8'h00, 6'h0F, 1'b0, acc);
    send(8'h00, 8'h00, 6'h00, 1'b1, acc);
    send(8'h10, 8'h10, 6'h01, 1'b1, acc);
    wait_out(acc, 6, "latency_wall2");

    // Reset mid-SEARCH, with in_valid also raised during reset.
    send(8'h41, 8'h6B, 6'h05, 1'b0, acc);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    cos_in   = 8'h47;
    sin_in   = 8'h6B;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_in_ready",  int'(in_ready),  1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_phase",     int'(phase_out), 0);
    chk("mid_rst_mismatch",  int'(mismatch),  0);
    repeat (12) @(negedge clk);

    // Backpressure: out_ready low for 10 cycles, then ena low in HOLD.
    out_ready = 1'b0;
    send(8'hAA, 8'hF5, 6'h23, 1'b0, acc);
    wait_out(acc, 6, "bp_latency");
    held = phase_out;
    bad  = 0;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || in_ready || phase_out !== held) bad++;
    end
    chk("bp_hold_bad_cycles", bad, 0);
    @(posedge clk);
    #1;
    ena       = 1'b0;
    out_ready = 1'b1;
    bad       = 0;
    repeat (2) begin
      @(negedge clk);
      if (!out_valid) bad++;
    end
    chk("ena_low_hold_bad_cycles", bad, 0);
    @(posedge clk);
    #1 ena = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready",  int'(in_ready),  1);
    chk("bp_release_out_valid", int'(out_valid), 0);

    // ena stall of 3 cycles mid-SEARCH.
    send(8'h78, 8'h9D, 6'h12, 1'b0, acc);
    @(posedge clk);
    #1 ena = 1'b0;
    repeat (3) @(posedge clk);
    #1 ena = 1'b1;
    wait_out(acc - 0, 9, "stall_latency_wall");

    // Full DAC sweep: exact except descending-quadrant fine 15 -> fine 14.
    for (int p = 0; p < 64; p++) begin
      d = dac(p);
      if ((p / 16) % 2 == 1 && p % 16 == 15)
        send(d[15:8], d[7:0], 6'(p - 1), 1'b0, acc);
      else
        send(d[15:8], d[7:0], 6'(p), 1'b0, acc);
    end

    // Random pairs against the reference decoder.
    for (int k = 0; k < 40; k++) begin
      rc = 8'($urandom);
      rs = 8'($urandom);
      r  = ref_decode(rc, rs);
      send(rc, rs, r[5:0], r[6], acc);
    end

    // Drain the scoreboard, bounded.
    for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
